// File: rtl/backward_registered_slice.sv
`default_nettype none
// ============================================================================
// Module   : backward_registered_slice
// Purpose  : Full valid/ready register slice with a 2-entry skid buffer;
//            every output, including m_ready, comes straight from a flop.
// Revision : 1.0 - initial release
// ============================================================================
module backward_registered_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_data,
    output logic             m_ready,
    output logic             s_valid,
    output logic [WIDTH-1:0] s_data,
    input  logic             s_ready,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             m_ready_q;
    logic             s_valid_q;
    logic             m_fire;
    logic             s_fire;

    assign m_fire = m_valid & m_ready_q;
    assign s_fire = s_valid_q & s_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (m_fire) begin
                    state_d = ST_BUSY;
                    main_d  = m_data;
                end
            end
            ST_BUSY: begin
                if (m_fire && s_fire) begin
                    main_d = m_data;
                end else if (m_fire) begin
                    state_d = ST_FULL;
                    skid_d  = m_data;
                end else if (s_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Upstream is blocked here, so only the drain side can move.
                if (s_fire) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            m_ready_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_ready_q <= (state_d != ST_FULL);
            s_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign m_ready   = m_ready_q;
    assign s_valid   = s_valid_q;
    assign s_data    = main_q;
    assign occupancy = state_q;

endmodule
`default_nettype wire

// File: tb/tb_backward_registered_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_backward_registered_slice
// Purpose  : Directed vector table, streaming sequence and random traffic
//            checked against a queue-based model of the slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_backward_registered_slice;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic [1:0]       occupancy;

    int total;
    int bad;

    // Reference model: ordered list of held words, capacity two.
    logic [WIDTH-1:0] mdl_q[$];
    logic [WIDTH-1:0] mdl_last;
    logic             mdl_ready;

    typedef struct {
        logic             rst;
        logic             mv;
        logic [WIDTH-1:0] md;
        logic             sr;
        logic             e_sv;
        logic [WIDTH-1:0] e_sd;
        logic             e_mr;
        logic [1:0]       e_occ;
    } vec_t;

    vec_t vecs[18];

    backward_registered_slice #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1ns later.
    task automatic step(input logic r, input logic mv, input logic [WIDTH-1:0] md, input logic sr);
        logic mf;
        logic sf;
        rst     = r;
        m_valid = mv;
        m_data  = md;
        s_ready = sr;
        @(posedge clk);
        if (r) begin
            mdl_q.delete();
            mdl_last  = '0;
            mdl_ready = 1'b0;
        end else begin
            mf = mv & mdl_ready;
            sf = sr & (mdl_q.size() != 0);
            if (sf) void'(mdl_q.pop_front());
            if (mf) mdl_q.push_back(md);
            if (mdl_q.size() != 0) mdl_last = mdl_q[0];
            mdl_ready = (mdl_q.size() < 2);
        end
        #1;
        chk("mdl_s_valid", {31'd0, s_valid}, {31'd0, mdl_q.size() != 0});
        chk("mdl_s_data", {24'd0, s_data}, {24'd0, mdl_last});
        chk("mdl_m_ready", {31'd0, m_ready}, {31'd0, mdl_ready});
        chk("mdl_occupancy", {30'd0, occupancy}, mdl_q.size());
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        mdl_last  = '0;
        mdl_ready = 1'b0;
        rst       = 1'b1;
        m_valid   = 1'b0;
        m_data    = '0;
        s_ready   = 1'b0;

        //          rst   mv    md     sr    sv    sd     mr    occ
        vecs[0]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
        vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[9]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[10] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
        vecs[11] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 2'd0};
        vecs[14] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 2'd1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[17] = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].mv, vecs[i].md, vecs[i].sr);
            chk($sformatf("vec%0d_s_valid", i), {31'd0, s_valid}, {31'd0, vecs[i].e_sv});
            chk($sformatf("vec%0d_s_data", i), {24'd0, s_data}, {24'd0, vecs[i].e_sd});
            chk($sformatf("vec%0d_m_ready", i), {31'd0, m_ready}, {31'd0, vecs[i].e_mr});
            chk($sformatf("vec%0d_occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
        end

        // Streaming from EMPTY: one word accepted and presented per cycle.
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, i[7:0], 1'b1);
            chk("stream_s_data", {24'd0, s_data}, i);
            chk("stream_m_ready", {31'd0, m_ready}, 32'd1);
            chk("stream_occupancy", {30'd0, occupancy}, 32'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_s_valid", {31'd0, s_valid}, 32'd0);
        chk("drain_s_data_hold", {24'd0, s_data}, 32'd10);

        // Random traffic with shifting bias per block.
        for (int blk = 0; blk < 10; blk++) begin
            int pv;
            int pr;
            pv = $urandom_range(1, 9);
            pr = $urandom_range(1, 9);
            for (int c = 0; c < 1000; c++) begin
                logic r;
                r = ($urandom_range(0, 999) == 0);
                step(r, ($urandom_range(0, 9) < pv), 8'($urandom), ($urandom_range(0, 9) < pr));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/backward_registered_slice.md
Name: backward_registered_slice

Overview:
- Full register slice for the valid/ready stream interface; the ready-path counterpart to the team's forward (valid/data) register stage.
- m_ready is driven from a flop, so the long combinational s_ready path is broken. s_valid/s_data are also registered.
- A 2-entry skid buffer with a 3-state FSM sustains one transfer per cycle.
- Sits between any upstream master and downstream slave on a timing-critical stream hop.

Parameters:
- WIDTH, 8, data bus width in bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- m_valid  input  1  upstream data valid.
- m_data  input  WIDTH  upstream data.
- m_ready  output  1  ready to upstream; driven directly from a flop.
- s_valid  output  1  downstream data valid; registered.
- s_data  output  WIDTH  downstream data; registered.
- s_ready  input  1  downstream ready.
- occupancy  output  2  number of words held: 0, 1 or 2.

Behaviour:
- Definitions: m_fire = m_valid & m_ready; s_fire = s_valid & s_ready.
- Storage: main register (drives s_data) and skid register (internal).
- Reset, while rst=1 at a clock edge:
  - state=EMPTY, s_valid=0, s_data=0, skid=0, occupancy=0.
  - m_ready=0 during reset; m_ready=1 on the first edge after rst falls.
  - Reset mid-operation discards both held words; no transfer completes in that cycle.
- FSM, one transition per clock:
  - EMPTY (s_valid=0, m_ready=1, occupancy=0):
    - m_fire -> BUSY; main<=m_data.
    - else stay.
  - BUSY (s_valid=1, m_ready=1, occupancy=1):
    - m_fire & s_fire -> BUSY; main<=m_data.
    - m_fire & !s_fire -> FULL; skid<=m_data, main unchanged.
    - !m_fire & s_fire -> EMPTY.
    - neither -> stay.
  - FULL (s_valid=1, m_ready=0, occupancy=2):
    - s_fire -> BUSY; main<=skid.
    - else stay.
    - m_valid/m_data are ignored in FULL.
- m_ready is a registered copy of (next_state != FULL). No combinational path from any input to any output.
- Latency: a word accepted at edge N is presented on s_data from edge N onward (visible the cycle after acceptance).
- Throughput: 1 word/cycle sustained when s_ready=1 continuously.
- Ordering: strict FIFO; no word dropped or duplicated.
- Output stability: while s_valid=1 & s_ready=0, s_valid and s_data must not change.
- s_data holds its last value when s_valid=0; it is not cleared on drain.
- Input data: m_data is sampled only on m_fire; its value is don't-care otherwise.
- Upstream may drop m_valid at any time. The slice never requires m_valid to stay high.
- occupancy equals the state encoding at all times (EMPTY=0, BUSY=1, FULL=2). Value 3 is illegal; the verifier asserts it never occurs.

Test Plan:
- Reset: rst=1 for 3 cycles with m_valid=1, m_data=8'hAA -> s_valid=0, s_data=0, m_ready=0, occupancy=0 throughout; m_ready=1 on the first edge after rst=0.
- Streaming: s_ready=1, m_valid=1 with m_data=1,2,3,...,10 on consecutive cycles -> s_data=1..10 on consecutive cycles, each one cycle after acceptance; m_ready stays 1; occupancy stays 1 after the first word.
- Backpressure fill: in BUSY holding 8'h11, set s_ready=0 and send 8'h22 -> FULL, m_ready=0 next cycle, occupancy=2, s_data holds 8'h11. Then s_ready=1 -> 8'h11 then 8'h22 delivered in order; m_ready returns to 1.
- Stall while FULL: hold s_ready=0 for 5 cycles with m_valid=1, m_data=8'h33 -> no acceptance; s_valid=1 and s_data=8'h11 stable every cycle; 8'h33 is accepted only after m_ready returns to 1.
- Simultaneous events in BUSY: m_fire and s_fire on the same edge -> state stays BUSY, s_data becomes the new word, occupancy=1.
- Random traffic: 10k cycles of random m_valid/s_ready with scoreboard -> all words received in order with none lost; s_valid/s_data never change while stalled; no combinational input-to-output path found by the lint check.
